// File: rtl/svm_pkg.sv
// svm_pkg: constants and types shared between the SVM classifier core and
// its stream feeder.
//   IMG_LEN    words per image and per support vector
//   NUM_CORES  number of classes
//   SV_COUNT   support vectors per class
//   seg_t      segment the core expects next
//   state_t    feeder sequencer states
package svm_pkg;

  localparam int IMG_LEN   = 784;
  localparam int NUM_CORES = 10;
  localparam int SV_COUNT [0:9] = '{361, 267, 581, 632, 480, 513, 376, 432, 751, 683};

  typedef enum logic [2:0] {IMG, SV, LAM, BIAS, FIN} seg_t;
  typedef enum logic [2:0] {IDLE, ARM, BURST, WAIT, DONE} state_t;

  // Out-of-range classes report zero support vectors.
  function automatic int sv_count(input int c);
    return (c >= 0 && c < 10) ? SV_COUNT[c] : 0;
  endfunction

endpackage

// File: rtl/svm_stream_feeder_if.sv
// svm_stream_feeder_if: memory read port plus the outgoing data stream.
//   m_en/m_addr  read request (feeder -> memory)
//   m_data       read data, one cycle after m_en (memory -> feeder)
//   sdata/svalid stream beat (feeder -> core)
//   sready       stream ready (core -> feeder)
interface svm_stream_feeder_if #(
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 20
);
  logic              m_en;
  logic [AWIDTH-1:0] m_addr;
  logic [WIDTH-1:0]  m_data;
  logic [WIDTH-1:0]  sdata;
  logic              svalid;
  logic              sready;

  modport master (output m_en, m_addr, sdata, svalid, input m_data, sready);
  modport slave  (input m_en, m_addr, sdata, svalid, output m_data, sready);
endinterface

// File: rtl/svm_skid_fifo.sv
// svm_skid_fifo: 2-entry FIFO absorbing read data that cannot be streamed
// out immediately.
//   clk_i, reset_i  clock, synchronous active-high reset
//   push_i, din_i   write one word (ignored when full and not popping)
//   pop_i           drop the head word (ignored when empty)
//   dout_o          head word
//   full_o, empty_o occupancy flags
//   count_o         occupancy 0..2
module svm_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  rd_q, wr_q;
  logic [1:0]            cnt_q;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/svm_stream_feeder.sv
// svm_stream_feeder: on each core interrupt, reads the next segment (image,
// support vector, lambda or bias) from memory and streams it to the core.
//   clk_i, reset_i   clock, synchronous active-high reset
//   start_i          arm a run (IDLE only); samples the four base addresses
//   *_base_i         segment base addresses
//   interrupt_i      phase pulse from the core
//   bus              memory read port + output stream (master side)
//   busy_o           run in progress
//   done_o           one-cycle pulse after the final interrupt
//   err_o            sticky: interrupt seen while not expecting one
module svm_stream_feeder #(
  parameter int WIDTH     = 16,
  parameter int AWIDTH    = 20,
  parameter int IMG_LEN   = svm_pkg::IMG_LEN,
  parameter int NUM_CORES = svm_pkg::NUM_CORES
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] img_base_i,
  input  logic [AWIDTH-1:0] sv_base_i,
  input  logic [AWIDTH-1:0] lam_base_i,
  input  logic [AWIDTH-1:0] bias_base_i,
  input  logic              interrupt_i,
  svm_stream_feeder_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  import svm_pkg::*;

  localparam int RW = $clog2(IMG_LEN + 1);
  localparam int CW = $clog2(NUM_CORES + 1);

  state_t            state_q, state_d;
  seg_t              seg_q, seg_d;
  logic [AWIDTH-1:0] img_base_q, img_base_d, bias_base_q, bias_base_d;
  logic [AWIDTH-1:0] sv_ptr_q, sv_ptr_d, lam_ptr_q, lam_ptr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     core_q, core_d;
  logic [15:0]       sv_cnt_q, sv_cnt_d;
  logic              err_q, err_d;
  logic              pend_q;   // read issued last cycle, data on m_data now

  logic              f_push, f_pop, f_full, f_empty;
  logic [1:0]        f_cnt, occ;
  logic [WIDTH-1:0]  f_head;
  logic              issue, xfer, drained;

  svm_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .din_i   (bus.m_data),
    .dout_o  (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  // Returning read data bypasses the FIFO when it is empty, so a burst
  // streams out one cycle after its first read. Data only enters the FIFO
  // when it cannot leave in the cycle it arrives.
  assign bus.svalid = !f_empty || pend_q;
  assign bus.sdata  = !f_empty ? f_head : (pend_q ? bus.m_data : '0);
  assign xfer       = bus.svalid && bus.sready;
  assign f_pop      = !f_empty && bus.sready;
  assign f_push     = pend_q && !(f_empty && bus.sready);

  // In-flight read counts as occupied so the FIFO can always take it.
  assign occ     = f_cnt + {1'b0, pend_q};
  assign issue   = (state_q == BURST) && (rem_q != '0) && (occ < 2'd2) && !f_full;
  assign drained = (rem_q == '0) && ((occ == 2'd0) || ((occ == 2'd1) && xfer));

  assign bus.m_en   = issue;
  assign bus.m_addr = addr_q;
  assign busy_o     = state_q inside {ARM, BURST, WAIT};
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    img_base_d  = img_base_q;
    bias_base_d = bias_base_q;
    sv_ptr_d    = sv_ptr_q;
    lam_ptr_d   = lam_ptr_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    core_d      = core_q;
    sv_cnt_d    = sv_cnt_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          img_base_d  = img_base_i;
          bias_base_d = bias_base_i;
          sv_ptr_d    = sv_base_i;
          lam_ptr_d   = lam_base_i;
          seg_d       = IMG;
          core_d      = '0;
          sv_cnt_d    = '0;
          err_d       = 1'b0;
          state_d     = ARM;
        end else if (interrupt_i) begin
          err_d = 1'b1;
        end
      end
      ARM, WAIT: begin
        if (interrupt_i) begin
          if (seg_q == FIN) begin
            state_d = DONE;
          end else begin
            state_d = BURST;
            case (seg_q)
              IMG:     begin addr_d = img_base_q; rem_d = RW'(IMG_LEN); end
              SV:      begin addr_d = sv_ptr_q;   rem_d = RW'(IMG_LEN); end
              LAM:     begin addr_d = lam_ptr_q;  rem_d = RW'(1); end
              BIAS:    begin addr_d = bias_base_q + AWIDTH'(core_q); rem_d = RW'(1); end
              default: state_d = WAIT;
            endcase
          end
        end
      end
      BURST: begin
        // A stray interrupt is flagged but does not disturb the burst.
        if (interrupt_i) err_d = 1'b1;
        if (issue) begin
          addr_d = addr_q + AWIDTH'(1);
          rem_d  = rem_q - RW'(1);
        end
        if (drained) begin
          state_d = WAIT;
          case (seg_q)
            IMG: seg_d = SV;
            SV: begin
              seg_d    = LAM;
              sv_ptr_d = sv_ptr_q + AWIDTH'(IMG_LEN);
            end
            LAM: begin
              sv_cnt_d  = sv_cnt_q + 16'd1;
              lam_ptr_d = lam_ptr_q + AWIDTH'(1);
              seg_d     = (sv_cnt_d == 16'(sv_count(int'(core_q)))) ? BIAS : SV;
            end
            BIAS: begin
              core_d   = core_q + CW'(1);
              sv_cnt_d = '0;
              seg_d    = (core_d == CW'(NUM_CORES)) ? FIN : SV;
            end
            default: seg_d = seg_q;
          endcase
        end
      end
      DONE: begin
        if (interrupt_i) err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      seg_q       <= IMG;
      img_base_q  <= '0;
      bias_base_q <= '0;
      sv_ptr_q    <= '0;
      lam_ptr_q   <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      core_q      <= '0;
      sv_cnt_q    <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      img_base_q  <= img_base_d;
      bias_base_q <= bias_base_d;
      sv_ptr_q    <= sv_ptr_d;
      lam_ptr_q   <= lam_ptr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      core_q      <= core_d;
      sv_cnt_q    <= sv_cnt_d;
      err_q       <= err_d;
      pend_q      <= issue;
    end
  end

endmodule
